// File: rtl/shader_pkg.sv
// Shared types and constants for the shader sequencer and its memory.
// The optional PAD state only exists when SHADER_SEQ_LOAD_TIMEOUT_EN is defined.
package shader_pkg;

    typedef logic [7:0] instr_t;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_EXEC = 2'd1,
`ifdef SHADER_SEQ_LOAD_TIMEOUT_EN
        ST_LOAD = 2'd2,
        ST_PAD  = 2'd3
`else
        ST_LOAD = 2'd2
`endif
    } seq_state_e;

    localparam instr_t NOP = 8'b01_00_00_00;

    // Counter width for values 0..n-1, never narrower than one bit.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/shader_sequencer.sv
// shader_sequencer: owns the shift/load port of the shader instruction
// shift-register memory. Replays the program once per pixel (NUM_INSTR
// rotations) and streams new program bytes in between pixels.
// Optional feature: SHADER_SEQ_LOAD_TIMEOUT_EN adds a load-session timeout
// that pads a short session with rotations so slot 0 stays at word 0.
//
// state | meaning
// IDLE  | waiting for a pixel request or the first byte of a load session
// EXEC  | rotating the memory, one instruction slot per cycle
// LOAD  | accepting program bytes, one shift-load per accepted byte
// PAD   | (timeout build only) rotating the remaining slots after a stall
module shader_sequencer
    import shader_pkg::*;
#(
    parameter int NUM_INSTR      = 16,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                         clk_i,
    input  logic                         rst_ni,
    input  logic                         pixel_start_i,
    output logic                         exec_valid_o,
    output logic [$clog2(NUM_INSTR)-1:0] exec_idx_o,
    output logic                         exec_last_o,
    output logic                         pixel_miss_o,
    input  logic                         byte_valid_i,
    input  logic [7:0]                   byte_data_i,
    output logic                         byte_ready_o,
    output logic                         load_done_o,
    output logic                         load_timeout_o,
    output logic                         shift_o,
    output logic                         load_o,
    output logic [7:0]                   instr_o,
    output logic                         busy_o
);

    localparam int IW = $clog2(NUM_INSTR);
    localparam int CW = idx_w(NUM_INSTR + 1);

    if (NUM_INSTR < 2) begin : g_bad_num_instr
        $error("shader_sequencer: NUM_INSTR must be at least 2");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
        $error("shader_sequencer: TIMEOUT_CYCLES must be at least 1");
    end

    seq_state_e      state_q, state_d;
    logic [IW-1:0]   idx_q, idx_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic            miss_q, miss_d;
    logic            ld_shift_q;
    logic            ld_last_q;
    instr_t          instr_q;
    logic            ready;
    logic            accept;
    logic            idx_end;
    logic            cnt_end;

`ifdef SHADER_SEQ_LOAD_TIMEOUT_EN
    localparam int TW = idx_w(TIMEOUT_CYCLES);
    logic [TW-1:0]   tmo_q, tmo_d;
    logic [CW-1:0]   pad_q, pad_d;
`endif

    assign ready   = ((state_q == ST_IDLE) && !pixel_start_i) || (state_q == ST_LOAD);
    assign accept  = byte_valid_i && ready;
    assign idx_end = (idx_q == IW'(NUM_INSTR - 1));
    assign cnt_end = (cnt_q == CW'(NUM_INSTR - 1));

    // Next-state, slot index, load count and drop detection.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        miss_d  = 1'b0;
`ifdef SHADER_SEQ_LOAD_TIMEOUT_EN
        tmo_d   = tmo_q;
        pad_d   = pad_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (pixel_start_i) begin
                    state_d = ST_EXEC;
                    idx_d   = '0;
                end else if (accept) begin
                    state_d = ST_LOAD;
                    cnt_d   = CW'(1);
`ifdef SHADER_SEQ_LOAD_TIMEOUT_EN
                    tmo_d   = TW'(TIMEOUT_CYCLES - 1);
`endif
                end
            end
            ST_EXEC: begin
                if (idx_end) begin
                    idx_d = '0;
                    if (!pixel_start_i) begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    idx_d  = idx_q + IW'(1);
                    miss_d = pixel_start_i;
                end
            end
            ST_LOAD: begin
                miss_d = pixel_start_i;
                if (accept) begin
                    if (cnt_end) begin
                        state_d = ST_IDLE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d   = cnt_q + CW'(1);
                    end
`ifdef SHADER_SEQ_LOAD_TIMEOUT_EN
                    tmo_d = TW'(TIMEOUT_CYCLES - 1);
                end else if (tmo_q == '0) begin
                    state_d = ST_PAD;
                    pad_d   = CW'(NUM_INSTR) - cnt_q;
                end else begin
                    tmo_d = tmo_q - TW'(1);
`endif
                end
            end
`ifdef SHADER_SEQ_LOAD_TIMEOUT_EN
            ST_PAD: begin
                miss_d = pixel_start_i;
                pad_d  = pad_q - CW'(1);
                if (pad_q == CW'(1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end
            end
`endif
            default: begin
                state_d = ST_IDLE;
                idx_d   = '0;
                cnt_d   = '0;
            end
        endcase
    end

    // State and counter registers.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            cnt_q   <= '0;
            miss_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            miss_q  <= miss_d;
        end
    end

`ifdef SHADER_SEQ_LOAD_TIMEOUT_EN
    // Stall timer and remaining-rotation counter for short load sessions.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tmo_q <= '0;
            pad_q <= '0;
        end else begin
            tmo_q <= tmo_d;
            pad_q <= pad_d;
        end
    end
`endif

    // Accepted bytes are registered and written one cycle later.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ld_shift_q <= 1'b0;
            ld_last_q  <= 1'b0;
            instr_q    <= '0;
        end else begin
            ld_shift_q <= accept;
            ld_last_q  <= accept && (state_q == ST_LOAD) && cnt_end;
            if (accept) begin
                instr_q <= byte_data_i;
            end
        end
    end

    // Output decode; load shifts never coincide with EXEC or PAD rotations.
    always_comb begin
        exec_valid_o = (state_q == ST_EXEC);
        exec_idx_o   = idx_q;
        exec_last_o  = (state_q == ST_EXEC) && idx_end;
        pixel_miss_o = miss_q;
        byte_ready_o = ready;
        load_done_o  = ld_last_q;
        load_o       = ld_shift_q;
        instr_o      = instr_q;
        busy_o       = (state_q != ST_IDLE);
`ifdef SHADER_SEQ_LOAD_TIMEOUT_EN
        shift_o        = (state_q == ST_EXEC) || (state_q == ST_PAD) || ld_shift_q;
        load_timeout_o = (state_q == ST_PAD) && (pad_q == CW'(1));
`else
        shift_o        = (state_q == ST_EXEC) || ld_shift_q;
        load_timeout_o = 1'b0;
`endif
    end

endmodule

// File: tb/tb_shader_sequencer.sv
// Self-checking bench for shader_sequencer. A behavioural shift-register
// memory hangs off shift/load/instr; the expected program is tracked as a
// plain array of slot contents updated by whole load sessions.
// Timeout scenario runs only when SHADER_SEQ_LOAD_TIMEOUT_EN is defined.
module tb_shader_sequencer;

    localparam int N   = 16;
    localparam int TMO = 8;
    localparam int IW  = $clog2(N);

    logic          clk_i = 1'b0;
    logic          rst_ni = 1'b0;
    logic          pixel_start_i = 1'b0;
    logic          exec_valid_o;
    logic [IW-1:0] exec_idx_o;
    logic          exec_last_o;
    logic          pixel_miss_o;
    logic          byte_valid_i = 1'b0;
    logic [7:0]    byte_data_i = 8'h00;
    logic          byte_ready_o;
    logic          load_done_o;
    logic          load_timeout_o;
    logic          shift_o;
    logic          load_o;
    logic [7:0]    instr_o;
    logic          busy_o;

    int            checks = 0;
    int            failures = 0;
    logic [7:0]    prog [N];
    logic [7:0]    mem  [N];
    logic [7:0]    last_byte = 8'h00;

    shader_sequencer #(.NUM_INSTR(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clk_i          (clk_i),
        .rst_ni         (rst_ni),
        .pixel_start_i  (pixel_start_i),
        .exec_valid_o   (exec_valid_o),
        .exec_idx_o     (exec_idx_o),
        .exec_last_o    (exec_last_o),
        .pixel_miss_o   (pixel_miss_o),
        .byte_valid_i   (byte_valid_i),
        .byte_data_i    (byte_data_i),
        .byte_ready_o   (byte_ready_o),
        .load_done_o    (load_done_o),
        .load_timeout_o (load_timeout_o),
        .shift_o        (shift_o),
        .load_o         (load_o),
        .instr_o        (instr_o),
        .busy_o         (busy_o)
    );

    always #5 clk_i = ~clk_i;

    function automatic logic [7:0] default_byte(input int i);
        case (i)
            0: return 8'h80;
            1: return 8'h85;
            2: return 8'hC0;
            3: return 8'h8A;
            4: return 8'hC4;
            5: return 8'h90;
            default: return 8'h40;
        endcase
    endfunction

    // Behavioural shader memory: word 0 is read, a shift moves word 1 down.
    always @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < N; i++) mem[i] <= default_byte(i);
        end else if (shift_o) begin
            for (int i = 0; i < N - 1; i++) mem[i] <= mem[i + 1];
            mem[N - 1] <= load_o ? instr_o : mem[0];
        end
    end

    // One clock cycle: drive at the falling edge, outputs settle 1 ns later.
    task automatic cyc(input logic ps, input logic bv, input logic [7:0] bd);
        @(negedge clk_i);
        pixel_start_i = ps;
        byte_valid_i  = bv;
        byte_data_i   = bd;
        #1;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        pixel_start_i = 1'b0;
        byte_valid_i  = 1'b0;
        repeat (3) @(negedge clk_i);
        #1;
        checks++;
        if ({exec_valid_o, exec_idx_o, exec_last_o, pixel_miss_o, load_done_o, load_timeout_o,
             shift_o, load_o, instr_o, busy_o} !== '0) begin
            failures++;
            $display("FAIL reset_outputs: got %b want all zero",
                     {exec_valid_o, exec_idx_o, exec_last_o, pixel_miss_o, load_done_o,
                      load_timeout_o, shift_o, load_o, instr_o, busy_o});
        end
        checks++;
        if (byte_ready_o !== 1'b1) begin
            failures++;
            $display("FAIL reset_ready: got %b want 1", byte_ready_o);
        end
        for (int i = 0; i < N; i++) prog[i] = default_byte(i);
        last_byte = 8'h00;
        @(negedge clk_i);
        rst_ni = 1'b1;
    endtask

    task automatic test_exec();
        cyc(1'b1, 1'b0, 8'h00);
        checks++;
        if ({exec_valid_o, byte_ready_o} !== 2'b00) begin
            failures++;
            $display("FAIL exec_request: valid/ready got %b want 00", {exec_valid_o, byte_ready_o});
        end
        for (int i = 0; i < N; i++) begin
            cyc(1'b0, 1'b0, 8'h00);
            checks++;
            if ({exec_valid_o, exec_idx_o, exec_last_o, shift_o, load_o, busy_o, byte_ready_o, pixel_miss_o}
                !== {1'b1, IW'(i), (i == N - 1), 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL exec_slot%0d: valid,idx,last,shift,load,busy,ready,miss got %b %0d %b%b%b%b%b%b",
                         i, exec_valid_o, exec_idx_o, exec_last_o, shift_o, load_o, busy_o, byte_ready_o, pixel_miss_o);
            end
            checks++;
            if (mem[0] !== prog[i]) begin
                failures++;
                $display("FAIL exec_instr%0d: got %h want %h", i, mem[0], prog[i]);
            end
        end
        cyc(1'b0, 1'b0, 8'h00);
        checks++;
        if ({exec_valid_o, busy_o, shift_o, byte_ready_o} !== 4'b0001) begin
            failures++;
            $display("FAIL exec_end: valid,busy,shift,ready got %b want 0001",
                     {exec_valid_o, busy_o, shift_o, byte_ready_o});
        end
    endtask

    task automatic test_back_to_back();
        cyc(1'b1, 1'b0, 8'h00);
        for (int run = 0; run < 2; run++) begin
            for (int i = 0; i < N; i++) begin
                cyc((run == 0) && (i == N - 1), 1'b0, 8'h00);
                checks++;
                if ({exec_valid_o, exec_idx_o, exec_last_o, pixel_miss_o}
                    !== {1'b1, IW'(i), (i == N - 1), 1'b0}) begin
                    failures++;
                    $display("FAIL b2b_run%0d_slot%0d: valid,idx,last,miss got %b %0d %b %b",
                             run, i, exec_valid_o, exec_idx_o, exec_last_o, pixel_miss_o);
                end
                checks++;
                if (mem[0] !== prog[i]) begin
                    failures++;
                    $display("FAIL b2b_instr%0d: got %h want %h", i, mem[0], prog[i]);
                end
            end
        end
        cyc(1'b0, 1'b0, 8'h00);
        checks++;
        if (exec_valid_o !== 1'b0) begin
            failures++;
            $display("FAIL b2b_end: valid got %b want 0", exec_valid_o);
        end
    endtask

    task automatic test_miss();
        int r;
        r = $urandom_range(0, N - 2);
        cyc(1'b1, 1'b0, 8'h00);
        for (int i = 0; i < N; i++) begin
            cyc(i == r, 1'b0, 8'h00);
            checks++;
            if ({exec_valid_o, exec_idx_o, pixel_miss_o} !== {1'b1, IW'(i), (i == r + 1)}) begin
                failures++;
                $display("FAIL miss_r%0d_slot%0d: valid,idx,miss got %b %0d %b", r, i,
                         exec_valid_o, exec_idx_o, pixel_miss_o);
            end
        end
        cyc(1'b0, 1'b0, 8'h00);
        checks++;
        if ({exec_valid_o, pixel_miss_o} !== 2'b00) begin
            failures++;
            $display("FAIL miss_no_restart: valid,miss got %b want 00", {exec_valid_o, pixel_miss_o});
        end
    endtask

    task automatic test_load();
        logic [7:0] nb [N];
        logic [7:0] bd;
        logic       bv;
        int         k;
        int         idle_run;
        int         guard;
        logic       pend;
        k = 0; idle_run = 0; guard = 0; pend = 1'b0;
        while (k < N && guard < 200) begin
            bv = ($urandom_range(0, 3) != 0) || (idle_run >= 2);
            bd = 8'($urandom);
            cyc(1'b0, bv, bd);
            checks++;
            if ({byte_ready_o, busy_o, shift_o, load_o, load_done_o, load_timeout_o, exec_valid_o, instr_o}
                !== {1'b1, (k > 0), pend, pend, 1'b0, 1'b0, 1'b0, last_byte}) begin
                failures++;
                $display("FAIL load_k%0d: ready,busy,shift,load,done,tmo,valid got %b%b%b%b%b%b%b instr %h want instr %h",
                         k, byte_ready_o, busy_o, shift_o, load_o, load_done_o, load_timeout_o, exec_valid_o,
                         instr_o, last_byte);
            end
            pend = bv;
            if (bv) begin
                nb[k] = bd;
                k++;
                last_byte = bd;
                idle_run = 0;
            end else begin
                idle_run++;
            end
            guard++;
        end
        cyc(1'b0, 1'b0, 8'h00);
        checks++;
        if ({shift_o, load_o, load_done_o, busy_o, instr_o} !== {1'b1, 1'b1, 1'b1, 1'b0, last_byte}) begin
            failures++;
            $display("FAIL load_last: shift,load,done,busy got %b%b%b%b instr %h want 1110 %h",
                     shift_o, load_o, load_done_o, busy_o, instr_o, last_byte);
        end
        for (int i = 0; i < N; i++) prog[i] = nb[i];
        test_exec();
    endtask

    task automatic test_priority();
        cyc(1'b1, 1'b1, 8'h10);
        checks++;
        if ({byte_ready_o, exec_valid_o} !== 2'b00) begin
            failures++;
            $display("FAIL prio_request: ready,valid got %b want 00", {byte_ready_o, exec_valid_o});
        end
        for (int i = 0; i < N; i++) begin
            cyc(1'b0, 1'b1, 8'h10);
            checks++;
            if ({exec_valid_o, exec_idx_o, byte_ready_o, load_o} !== {1'b1, IW'(i), 1'b0, 1'b0}) begin
                failures++;
                $display("FAIL prio_exec%0d: valid,idx,ready,load got %b %0d %b%b", i,
                         exec_valid_o, exec_idx_o, byte_ready_o, load_o);
            end
        end
        for (int j = 0; j < N; j++) begin
            cyc(1'b0, 1'b1, 8'h10 + 8'(j));
            checks++;
            if ({byte_ready_o, exec_valid_o, load_o, load_done_o, busy_o, instr_o}
                !== {1'b1, 1'b0, (j > 0), 1'b0, (j > 0), (j > 0) ? 8'h10 + 8'(j - 1) : last_byte}) begin
                failures++;
                $display("FAIL prio_load%0d: ready,valid,load,done,busy got %b%b%b%b%b instr %h", j,
                         byte_ready_o, exec_valid_o, load_o, load_done_o, busy_o, instr_o);
            end
        end
        cyc(1'b0, 1'b0, 8'h00);
        checks++;
        if ({load_o, load_done_o, busy_o, instr_o} !== {1'b1, 1'b1, 1'b0, 8'h1F}) begin
            failures++;
            $display("FAIL prio_done: load,done,busy got %b%b%b instr %h want 110 1f",
                     load_o, load_done_o, busy_o, instr_o);
        end
        last_byte = 8'h1F;
        for (int i = 0; i < N; i++) prog[i] = 8'h10 + 8'(i);
        test_exec();
    endtask

    task automatic test_load_miss();
        logic [7:0] nb [N];
        int         m;
        m = $urandom_range(1, N - 1);
        for (int j = 0; j < N; j++) nb[j] = 8'($urandom);
        for (int j = 0; j < N; j++) begin
            cyc(j == m, 1'b1, nb[j]);
            checks++;
            if ({byte_ready_o, exec_valid_o, pixel_miss_o, load_o} !== {1'b1, 1'b0, (j == m + 1), (j > 0)}) begin
                failures++;
                $display("FAIL lmiss_m%0d_j%0d: ready,valid,miss,load got %b%b%b%b", m, j,
                         byte_ready_o, exec_valid_o, pixel_miss_o, load_o);
            end
        end
        cyc(1'b1, 1'b0, 8'h00);
        checks++;
        if ({shift_o, load_o, load_done_o, byte_ready_o, exec_valid_o, pixel_miss_o}
            !== {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, (m == N - 1)}) begin
            failures++;
            $display("FAIL lmiss_last_shift: shift,load,done,ready,valid,miss got %b%b%b%b%b%b",
                     shift_o, load_o, load_done_o, byte_ready_o, exec_valid_o, pixel_miss_o);
        end
        last_byte = nb[N - 1];
        for (int i = 0; i < N; i++) prog[i] = nb[i];
        for (int i = 0; i < N; i++) begin
            cyc(1'b0, 1'b0, 8'h00);
            checks++;
            if ({exec_valid_o, exec_idx_o, load_o, mem[0]} !== {1'b1, IW'(i), 1'b0, prog[i]}) begin
                failures++;
                $display("FAIL lmiss_exec%0d: valid %b idx %0d load %b instr %h want instr %h", i,
                         exec_valid_o, exec_idx_o, load_o, mem[0], prog[i]);
            end
        end
        cyc(1'b0, 1'b0, 8'h00);
    endtask

    task automatic test_reset_mid_load();
        logic [7:0] nb [N];
        for (int j = 0; j < 5; j++) cyc(1'b0, 1'b1, 8'($urandom));
        @(negedge clk_i);
        rst_ni = 1'b0;
        byte_valid_i = 1'b0;
        #1;
        checks++;
        if ({exec_valid_o, exec_idx_o, exec_last_o, pixel_miss_o, load_done_o, load_timeout_o,
             shift_o, load_o, instr_o, busy_o, byte_ready_o} !== 21'h1) begin
            failures++;
            $display("FAIL rst_mid_load: outputs got %b want 0 with ready 1",
                     {exec_valid_o, exec_idx_o, exec_last_o, pixel_miss_o, load_done_o, load_timeout_o,
                      shift_o, load_o, instr_o, busy_o, byte_ready_o});
        end
        for (int i = 0; i < N; i++) prog[i] = default_byte(i);
        last_byte = 8'h00;
        @(negedge clk_i);
        rst_ni = 1'b1;
        test_exec();
        for (int j = 0; j < N; j++) begin
            nb[j] = 8'($urandom);
            cyc(1'b0, 1'b1, nb[j]);
            checks++;
            if ({load_done_o, busy_o, byte_ready_o} !== {1'b0, (j > 0), 1'b1}) begin
                failures++;
                $display("FAIL rst_reload%0d: done,busy,ready got %b%b%b", j, load_done_o, busy_o, byte_ready_o);
            end
        end
        cyc(1'b0, 1'b0, 8'h00);
        checks++;
        if ({load_done_o, load_o, busy_o} !== 3'b110) begin
            failures++;
            $display("FAIL rst_reload_done: done,load,busy got %b want 110", {load_done_o, load_o, busy_o});
        end
        last_byte = nb[N - 1];
        for (int i = 0; i < N; i++) prog[i] = nb[i];
        test_exec();
    endtask

`ifdef SHADER_SEQ_LOAD_TIMEOUT_EN
    task automatic test_timeout();
        logic [7:0] nb [3];
        for (int j = 0; j < 3; j++) begin
            nb[j] = 8'($urandom);
            cyc(1'b0, 1'b1, nb[j]);
        end
        for (int j = 0; j < TMO; j++) begin
            cyc(1'b0, 1'b0, 8'h00);
            checks++;
            if ({byte_ready_o, busy_o, shift_o, load_o, load_timeout_o} !== {1'b1, 1'b1, (j == 0), (j == 0), 1'b0}) begin
                failures++;
                $display("FAIL tmo_wait%0d: ready,busy,shift,load,tmo got %b%b%b%b%b", j,
                         byte_ready_o, busy_o, shift_o, load_o, load_timeout_o);
            end
        end
        for (int p = 0; p < N - 3; p++) begin
            cyc(1'b0, 1'b1, 8'hEE);
            checks++;
            if ({byte_ready_o, busy_o, shift_o, load_o, load_timeout_o} !== {1'b0, 1'b1, 1'b1, 1'b0, (p == N - 4)}) begin
                failures++;
                $display("FAIL tmo_pad%0d: ready,busy,shift,load,tmo got %b%b%b%b%b", p,
                         byte_ready_o, busy_o, shift_o, load_o, load_timeout_o);
            end
        end
        cyc(1'b0, 1'b0, 8'h00);
        checks++;
        if ({busy_o, shift_o, load_timeout_o} !== 3'b000) begin
            failures++;
            $display("FAIL tmo_end: busy,shift,tmo got %b want 000", {busy_o, shift_o, load_timeout_o});
        end
        last_byte = nb[2];
        for (int i = 0; i < 3; i++) prog[i] = nb[i];
        test_exec();
    endtask
`endif

    initial begin
        test_reset();
        test_exec();
        test_back_to_back();
        test_miss();
        test_load();
        test_priority();
        test_load_miss();
        test_reset_mid_load();
`ifdef SHADER_SEQ_LOAD_TIMEOUT_EN
        test_timeout();
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
